sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Upstream pixel source for the VGA signal mux: scans one sprite from an external synchronous colour ROM and emits one pixel per cycle (x, y, colour, write strobe).
- Adds transparency keying, horizontal flip and screen-edge clipping.
- Uses a start/done level handshake, so its done can chain directly into the start of the next layer's blitter.

Parameters:
- X_MAX, 40, sprite width in pixels.
- Y_MAX, 40, sprite height in pixels.
- X_WIDTH, 6, column counter width (must hold X_MAX-1).
- Y_WIDTH, 6, row counter width (must hold Y_MAX-1).
- ADDR_WIDTH, 11, ROM address width (must hold X_MAX*Y_MAX-1).
- TRANSPARENT, 8'h09, colour key that is never written.
- SCREEN_W, 160, visible width.
- SCREEN_H, 120, visible height.

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-low reset
- start  in  1  level request; sampled only in IDLE
- x_init  in  8  screen x of sprite top-left; latched at start
- y_init  in  7  screen y of sprite top-left; latched at start
- flip_h  in  1  mirror horizontally; latched at start
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_data  in  8  ROM colour, valid one cycle after rom_addr
- x_out  out  8  pixel x
- y_out  out  7  pixel y
- colour  out  8  pixel colour
- write_en  out  1  plot strobe for x_out/y_out/colour
- busy  out  1  high in SCAN and FLUSH
- done  out  1  high in DONE

Behaviour:
- Reset (resetn=0 at a clk edge, including mid-scan): state IDLE; all counters, pipeline valids, rom_addr, x_out, y_out and colour = 0; write_en, busy and done = 0. An in-flight scan is abandoned; no further write_en is produced.
- IDLE: if start=1, latch x_init, y_init and flip_h, clear col, row and addr, then go to SCAN.
- SCAN (first cycle = T):
  - Pixel k (k = row*X_MAX + col) has rom_addr=k during cycle T+k.
  - addr is a running incrementer; no multiplier.
  - col wraps to 0 at X_MAX-1 and row then increments.
  - After pixel X_MAX*Y_MAX-1 is issued, go to FLUSH.
- Pipeline: 2 stages.
  - Stage 1 registers col, row and valid alongside the ROM access.
  - Stage 2 registers the outputs; outputs for pixel k are visible during cycle T+k+2.
- Output arithmetic:
  - x_out = x0 + (flip ? X_MAX-1-col : col), computed 9-bit then truncated to 8.
  - y_out = y0 + row, computed 8-bit then truncated to 7.
- write_en = stage-2 valid AND colour != TRANSPARENT AND 9-bit x sum < SCREEN_W AND 8-bit y sum < SCREEN_H.
  - Clipped or transparent pixels still advance the scan.
  - x_out, y_out and colour are still updated for these pixels, with write_en=0.
- FLUSH: exactly 2 cycles to drain the pipeline, then go to DONE.
- DONE: done=1, held while start=1. When start=0, go to IDLE next cycle; done is high for at least 1 cycle.
- Overall timing: done first rises at cycle T + X_MAX*Y_MAX + 2.
- start changes while busy are ignored. x_init, y_init and flip_h changes after latch are ignored.
- write_en is 0 in IDLE and DONE, and during cycles T and T+1.

Decomposition:
- Shared package: colour type (8-bit); screen constants SCREEN_W/SCREEN_H; TRANSPARENT key (8'h09); coordinate widths (x 8, y 7); state encoding IDLE=2'd0, SCAN=2'd1, FLUSH=2'd2, DONE=2'd3.
- One sub-module, sprite_scan_counter: col/row/addr generation with wrap and last-pixel flag; parameterised by X_MAX, Y_MAX and widths.
- Pipeline and FSM stay in sprite_blitter.

Test Plan:
- Bench setup: X_MAX=4, Y_MAX=3, ROM[k]=k+8'h10 (no transparent values).
- Basic scan, start held, x_init=10, y_init=20, flip=0 -> 12 write_en cycles at T+2..T+13; pixel 0 = (10,20,0x10); pixel 5 = (11,21,0x15); pixel 11 = (13,22,0x1B); done rises at T+14 and stays high until start=0, then IDLE.
- Flip, same setup with flip_h=1 -> pixel 0 = (13,20,0x10); pixel 3 = (10,20,0x13); rom_addr sequence unchanged (0..11).
- Transparency, ROM[5]=8'h09 -> 11 writes; cycle T+7 has write_en=0; scan length and done timing unchanged.
- Clipping, x_init=158, y_init=118 -> only pixels with col<2 and row<2 are written (4 writes); x sum 160 and y sum 120 suppressed, no wrap to 0.
- Reset mid-scan, resetn=0 at T+5 -> next cycle: IDLE, write_en=0, busy=0, done=0, all outputs 0. With start=1 and resetn=1 afterwards, a fresh scan starts at addr 0.
- Start ignored while busy: toggle start and x_init during SCAN -> all pixels keep the originally latched origin; done timing unchanged.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// Shared types and constants for the sprite blitter and its scan counter.
package sprite_blitter_pkg;

   localparam int X_COORD_W = 8;
   localparam int Y_COORD_W = 7;
   localparam int COLOUR_W  = 8;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [COLOUR_W-1:0] TRANSPARENT_KEY = 8'h09;

   typedef logic [COLOUR_W-1:0]  colour_t;
   typedef logic [X_COORD_W-1:0] xcoord_t;
   typedef logic [Y_COORD_W-1:0] ycoord_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/sprite_scan_counter.sv
// Walks a sprite in raster order: column, row and a running linear ROM
// address that is incremented alongside, so no multiplier is needed.
module sprite_scan_counter #(
   parameter int X_MAX      = 40,
   parameter int Y_MAX      = 40,
   parameter int X_WIDTH    = 6,
   parameter int Y_WIDTH    = 6,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clear_i,
   input  logic                  advance_i,
   output logic [X_WIDTH-1:0]    col_o,
   output logic [Y_WIDTH-1:0]    row_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  last_o
);

   localparam logic [X_WIDTH-1:0] COL_LAST = X_WIDTH'(X_MAX - 1);
   localparam logic [Y_WIDTH-1:0] ROW_LAST = Y_WIDTH'(Y_MAX - 1);

   logic [X_WIDTH-1:0]    col_q, col_d;
   logic [Y_WIDTH-1:0]    row_q, row_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;

   assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign col_o  = col_q;
   assign row_o  = row_q;
   assign addr_o = addr_q;

   // Next position: clear on request, otherwise step with column wrap into the next row.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      addr_d = addr_q;
      if (clear_i) begin
         col_d  = '0;
         row_d  = '0;
         addr_d = '0;
      end else if (advance_i) begin
         if (last_o) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
         end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = row_q + Y_WIDTH'(1);
            end else begin
               col_d = col_q + X_WIDTH'(1);
            end
         end
      end
   end

   // Position registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         col_q  <= '0;
         row_q  <= '0;
         addr_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         addr_q <= addr_d;
      end
   end

endmodule

// File: rtl/sprite_blitter.sv
// Scans one sprite from a synchronous colour ROM and emits one pixel per
// cycle with transparency keying, horizontal flip and screen-edge clipping.
// Two-stage pipeline: stage 1 waits on the ROM, stage 2 registers outputs.
module sprite_blitter
   import sprite_blitter_pkg::*;
#(
   parameter int      X_MAX       = 40,
   parameter int      Y_MAX       = 40,
   parameter int      X_WIDTH     = 6,
   parameter int      Y_WIDTH     = 6,
   parameter int      ADDR_WIDTH  = 11,
   parameter colour_t TRANSPARENT = TRANSPARENT_KEY,
   parameter int      SCREEN_W    = sprite_blitter_pkg::SCREEN_W,
   parameter int      SCREEN_H    = sprite_blitter_pkg::SCREEN_H
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [7:0]            x_init,
   input  logic [6:0]            y_init,
   input  logic                  flip_h,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [7:0]            rom_data,
   output logic [7:0]            x_out,
   output logic [6:0]            y_out,
   output logic [7:0]            colour,
   output logic                  write_en,
   output logic                  busy,
   output logic                  done
);

   state_e state_q, state_d;
   logic   flush_q, flush_d;
   logic   scanClear, scanAdvance, scanLast;

   xcoord_t x0_q;
   ycoord_t y0_q;
   logic    flip_q;

   logic [X_WIDTH-1:0] col;
   logic [Y_WIDTH-1:0] row;

   logic               s1_valid_q;
   logic [X_WIDTH-1:0] s1_col_q;
   logic [Y_WIDTH-1:0] s1_row_q;

   xcoord_t x_out_q;
   ycoord_t y_out_q;
   colour_t colour_q;
   logic    write_en_q;

   logic [X_WIDTH-1:0] xOffset;
   logic [8:0]         xSum;
   logic [7:0]         ySum;
   logic               visible;

   sprite_scan_counter #(
      .X_MAX     (X_MAX),
      .Y_MAX     (Y_MAX),
      .X_WIDTH   (X_WIDTH),
      .Y_WIDTH   (Y_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_scan (
      .clk      (clk),
      .resetn   (resetn),
      .clear_i  (scanClear),
      .advance_i(scanAdvance),
      .col_o    (col),
      .row_o    (row),
      .addr_o   (rom_addr),
      .last_o   (scanLast)
   );

   // FSM next state: start is only looked at in IDLE, FLUSH lasts two cycles.
   always_comb begin
      state_d     = state_q;
      flush_d     = flush_q;
      scanClear   = 1'b0;
      scanAdvance = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               scanClear = 1'b1;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            scanAdvance = 1'b1;
            if (scanLast) begin
               state_d = FLUSH;
               flush_d = 1'b0;
            end
         end
         FLUSH: begin
            flush_d = 1'b1;
            if (flush_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register plus the origin/flip latched once when a scan is accepted.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         flush_q <= 1'b0;
         x0_q    <= '0;
         y0_q    <= '0;
         flip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
         if (state_q == IDLE && start) begin
            x0_q   <= x_init;
            y0_q   <= y_init;
            flip_q <= flip_h;
         end
      end
   end

   // Stage-2 arithmetic: the sums keep their carry so off-screen pixels never wrap back on.
   always_comb begin
      xOffset = flip_q ? (X_WIDTH'(X_MAX - 1) - s1_col_q) : s1_col_q;
      xSum    = 9'(x0_q) + 9'(xOffset);
      ySum    = 8'(y0_q) + 8'(s1_row_q);
      visible = (rom_data != TRANSPARENT) &&
                (xSum < 9'(SCREEN_W)) &&
                (ySum < 8'(SCREEN_H));
   end

   // Two pipeline stages: stage 1 tracks the pixel during the ROM read, stage 2 drives the outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_valid_q <= 1'b0;
         s1_col_q   <= '0;
         s1_row_q   <= '0;
         x_out_q    <= '0;
         y_out_q    <= '0;
         colour_q   <= '0;
         write_en_q <= 1'b0;
      end else begin
         s1_valid_q <= (state_q == SCAN);
         s1_col_q   <= col;
         s1_row_q   <= row;
         write_en_q <= s1_valid_q && visible;
         if (s1_valid_q) begin
            x_out_q  <= xSum[7:0];
            y_out_q  <= ySum[6:0];
            colour_q <= rom_data;
         end
      end
   end

   assign x_out    = x_out_q;
   assign y_out    = y_out_q;
   assign colour   = colour_q;
   assign write_en = write_en_q;
   assign busy     = (state_q == SCAN) || (state_q == FLUSH);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter on a 4x3 sprite: stimulus queues the
// expected pixel writes, a negedge monitor pops and compares them.
module tb_sprite_blitter;

   localparam int XM = 4;
   localparam int YM = 3;
   localparam int N  = XM * YM;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [7:0]  xInit;
   logic [6:0]  yInit;
   logic        flipH;
   logic [10:0] romAddr;
   logic [7:0]  romData;
   logic [7:0]  xOut;
   logic [6:0]  yOut;
   logic [7:0]  colourOut;
   logic        writeEn;
   logic        busy;
   logic        done;

   logic [7:0] rom [0:N-1];

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [7:0] c;
      int         cyc;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   sprite_blitter #(
      .X_MAX     (XM),
      .Y_MAX     (YM),
      .X_WIDTH   (6),
      .Y_WIDTH   (6),
      .ADDR_WIDTH(11)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start),
      .x_init  (xInit),
      .y_init  (yInit),
      .flip_h  (flipH),
      .rom_addr(romAddr),
      .rom_data(romData),
      .x_out   (xOut),
      .y_out   (yOut),
      .colour  (colourOut),
      .write_en(writeEn),
      .busy    (busy),
      .done    (done)
   );

   // 100 MHz-ish bench clock and a free-running cycle counter
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROM model: data appears one cycle after the address
   always @(posedge clk) begin
      romData <= (romAddr < 11'(N)) ? rom[romAddr[3:0]] : 8'h00;
   end

   // Monitor: every write strobe must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (writeEn === 1'b1) begin
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_write: got (%0d,%0d,%h) at cyc %0d, required no write",
                     xOut, yOut, colourOut, cyc);
         end else begin
            e = expQ.pop_front();
            if (xOut !== e.x || yOut !== e.y || colourOut !== e.c || cyc != e.cyc) begin
               bad++;
               $display("[TB] FAIL pixel_write: got (%0d,%0d,%h)@%0d, required (%0d,%0d,%h)@%0d",
                        xOut, yOut, colourOut, cyc, e.x, e.y, e.c, e.cyc);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_write_en"}, 32'(writeEn), 0);
      checkOutput({tag, "_busy"}, 32'(busy), 0);
      checkOutput({tag, "_done"}, 32'(done), 0);
      checkOutput({tag, "_x_out"}, 32'(xOut), 0);
      checkOutput({tag, "_y_out"}, 32'(yOut), 0);
      checkOutput({tag, "_colour"}, 32'(colourOut), 0);
      checkOutput({tag, "_rom_addr"}, 32'(romAddr), 0);
   endtask

   // One full scan: queue expected writes, walk the scan checking addresses,
   // optionally disturb start/origin or reset partway, then check done timing.
   task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y, input logic f,
                                input bit wiggle, input int abortAt);
      int t0;
      int waitCnt;
      logic [8:0] xs;
      logic [7:0] ys;
      int col;
      int row;
      @(negedge clk);
      xInit = x;
      yInit = y;
      flipH = f;
      start = 1'b1;
      t0 = cyc + 1;
      for (int k = 0; k < N; k++) begin
         if (abortAt >= 0 && k + 2 > abortAt) continue;
         col = k % XM;
         row = k / XM;
         xs = 9'(x) + 9'(f ? (XM - 1 - col) : col);
         ys = 8'(y) + 8'(row);
         if (rom[k] != 8'h09 && xs < 9'd160 && ys < 8'd120)
            expQ.push_back('{x: xs[7:0], y: ys[6:0], c: rom[k], cyc: t0 + k + 2});
      end
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         checkOutput($sformatf("rom_addr_T%0d", i), 32'(romAddr), i);
         if (i < 2) checkOutput($sformatf("write_en_T%0d", i), 32'(writeEn), 0);
         if (i == 1) checkOutput("busy_scan", 32'(busy), 1);
         if (wiggle && i == 3) begin
            start = 1'b0;
            xInit = 8'd50;
            yInit = 7'd5;
            flipH = ~f;
         end
         if (wiggle && i == 6) start = 1'b1;
         if (i == abortAt) begin
            resetn = 1'b0;
            @(negedge clk);
            checkIdleZero("after_abort");
            resetn = 1'b1;
            start  = 1'b0;
            return;
         end
      end
      waitCnt = 0;
      do begin
         @(negedge clk);
         waitCnt++;
      end while (done !== 1'b1 && waitCnt < 20);
      checkOutput("done_cycle", 32'(cyc), 32'(t0 + N + 2));
      checkOutput("writes_left", 32'(expQ.size()), 0);
      @(negedge clk);
      checkOutput("done_held", 32'(done), 1);
      start = 1'b0;
      @(negedge clk);
      checkOutput("done_low_idle", 32'(done), 0);
      checkOutput("busy_idle", 32'(busy), 0);
      expQ.delete();
   endtask

   // Directed sequence: reset, basic, flip, transparency, clipping, abort, start ignored
   initial begin
      for (int k = 0; k < N; k++) rom[k] = 8'(k + 8'h10);
      resetn = 1'b0;
      start  = 1'b0;
      xInit  = '0;
      yInit  = '0;
      flipH  = 1'b0;
      repeat (3) @(negedge clk);
      checkIdleZero("reset");
      resetn = 1'b1;

      $display("[TB] basic scan");
      applyStimulus(8'd10, 7'd20, 1'b0, 1'b0, -1);

      $display("[TB] flip scan");
      applyStimulus(8'd10, 7'd20, 1'b1, 1'b0, -1);

      $display("[TB] transparent pixel 5");
      rom[5] = 8'h09;
      applyStimulus(8'd10, 7'd20, 1'b0, 1'b0, -1);
      rom[5] = 8'h15;

      $display("[TB] clipping at screen edge");
      applyStimulus(8'd158, 7'd118, 1'b0, 1'b0, -1);

      $display("[TB] reset mid-scan then fresh scan");
      applyStimulus(8'd10, 7'd20, 1'b0, 1'b0, 5);
      checkOutput("abort_writes_left", 32'(expQ.size()), 0);
      expQ.delete();
      applyStimulus(8'd10, 7'd20, 1'b0, 1'b0, -1);

      $display("[TB] start and origin changes ignored while busy");
      applyStimulus(8'd30, 7'd40, 1'b0, 1'b1, -1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
